diffusion_engine: RTL and testbench
===================================

DIFFUSION_ENGINE -- requirements
Module: diffusion_engine

Interface
REQ-001 SHALL have parameter NB, default 4, meaning number of 32-bit state columns per block (legal 1..8).
REQ-002 SHALL have the following ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  source offers a block.
- in_ready  output  1  engine can accept a block.
- in_mode  input  1  0 = forward diffusion (MixColumns), 1 = reverse diffusion (InvMixColumns).
- in_state  input  32*NB  block; column c = bits [32c+31:32c]; row r of a column = bits [8r+7:8r].
- out_valid  output  1  result block available.
- out_ready  input  1  sink accepts the result.
- out_state  output  32*NB  result block, same packing as in_state.
- busy  output  1  high in BUSY state.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-005 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-006 SHALL, on a rising edge with in_valid and in_ready both high, latch in_state into the working register and in_mode into the mode register, clear the column counter to 0, and enter BUSY.
REQ-007 SHALL, on each BUSY cycle, replace working column [col] with its GF(2^8) transform under the latched mode, then increment col.
- Forward matrix rows: {02 03 01 01}, rotated.
- Reverse matrix rows: {0e 0b 0d 09}, rotated.
- Reduction polynomial: 0x11b.
REQ-008 SHALL move BUSY to DONE on the edge that processes col = NB-1; the counter SHALL NOT wrap back into BUSY.
REQ-009 SHALL assert out_valid exactly NB cycles after the accept edge; latency is NB cycles.
REQ-010 SHALL, in DONE with out_ready high at an edge, return to IDLE.
- out_valid drops on the next cycle.
- A new block is not accepted on that same edge.
- Minimum block period is NB+2 cycles.
REQ-011 SHALL hold out_state stable while out_valid is high and out_ready is low, for any number of cycles.
REQ-012 SHALL ignore in_valid, in_state and in_mode while in BUSY or DONE.
REQ-013 SHALL drive out_state directly from the working register; values during BUSY are don't-care to the sink.
REQ-014 SHALL treat a mode change between blocks as affecting only the next accepted block.

Reset
REQ-015 SHALL, on reset assertion at any time including mid-BUSY or in DONE, immediately force the following, discarding any in-flight block:
- FSM to IDLE.
- in_ready = 1.
- out_valid = 0.
- busy = 0.
- Column counter = 0.
- Mode register = 0.
- Working register and out_state = all zeros.
REQ-016 SHALL accept a block on the first rising edge after reset deasserts if in_valid is high.

Structure
REQ-017 SHALL place the FSM state encoding, the NB default, and the GF(2^8) xtime/multiply helper functions in shared package diffusion_pkg.
REQ-018 SHALL instantiate exactly one combinational sub-module, diffusion_column.
- Inputs: 32-bit column and mode.
- Output: 32-bit transformed column.
- Shared across all columns by a counter-indexed mux.
- Reusable as the replacement for the existing fixed reverse-diffusion block.

Verification
REQ-019 SHALL verify forward mode, NB=4, with every column = row0..3 {db,13,53,45}: every out column = {8e,4d,a1,bc}, and out_valid rises 4 cycles after accept.
REQ-020 SHALL verify reverse mode with the columns below; each output SHALL be the forward input.
- {8e,4d,a1,bc} -> {db,13,53,45}.
- {9f,dc,58,9d} -> {f2,0a,22,5c}.
- {d5,d5,d7,d6} -> {d4,d4,d4,d5}.
- {4d,7e,bd,f8} -> {2d,26,31,4c}.
REQ-021 SHALL verify fixed points in both modes: columns {01,01,01,01} and {c6,c6,c6,c6} unchanged.
REQ-022 SHALL verify backpressure: out_ready held low 10 cycles -> out_valid high and out_state constant throughout, in_ready low, a new in_valid ignored; the block is accepted only after the DONE->IDLE transition.
REQ-023 SHALL verify reset pulsed on the 2nd BUSY cycle -> outputs at reset values immediately, no out_valid; the next block (forward, {db,13,53,45}) completes correctly.
REQ-024 SHALL verify NB=1 and NB=8 builds: forward then reverse round-trip of a random block returns the original, with out_valid at NB cycles after accept.

Source files
------------

// File: rtl/diffusion_pkg.sv
// Shared FSM encoding, block-size default and GF(2^8) arithmetic for the
// column-diffusion engine.
package diffusion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NB_DEFAULT = 4;

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/diffusion_column.sv
// Combinational single-column transform: MixColumns (mode 0) or
// InvMixColumns (mode 1) over GF(2^8).
module diffusion_column
  import diffusion_pkg::*;
(
  input  logic [31:0] column,
  input  logic        mode,
  output logic [31:0] result
);

  logic [7:0] coef [4];

  // Row r of the circulant matrix uses coef[(k - r) mod 4] for input byte k.
  always_comb begin
    if (mode) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    result = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        result[8*r +: 8] ^= gf_mul(coef[2'(k + 4 - r)], column[8*k +: 8]);
      end
    end
  end

endmodule

// File: rtl/diffusion_engine.sv
// Iterative block diffusion engine: one column per cycle through a shared
// column transform, valid/ready on both sides.
module diffusion_engine
  import diffusion_pkg::*;
#(
  parameter int unsigned NB = NB_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [32*NB-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_state,
  output logic            busy
);

  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  state_t          state, state_nx;
  logic [CW-1:0]   col;
  logic            mode_q;
  logic [32*NB-1:0] work;
  logic [31:0]     col_in;
  logic [31:0]     col_out;
  logic            accept;
  logic            last_col;

  assign accept    = in_valid && in_ready;
  assign last_col  = (col == CW'(NB - 1));
  assign out_state = work;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_col) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    col_in = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      if (col == CW'(c)) col_in = work[32*c +: 32];
    end
  end

  diffusion_column u_column (
    .column (col_in),
    .mode   (mode_q),
    .result (col_out)
  );

  // Counter parks on NB-1 after the last column; the next accept clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work   <= '0;
      col    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      work   <= in_state;
      mode_q <= in_mode;
      col    <= '0;
    end else if (state == BUSY) begin
      for (int unsigned c = 0; c < NB; c++) begin
        if (col == CW'(c)) work[32*c +: 32] <= col_out;
      end
      if (!last_col) col <= col + 1'b1;
    end
  end

endmodule

// File: tb/tb_diffusion_engine.sv
// Directed and randomized checks of diffusion_engine in NB=4, NB=1 and NB=8 builds.
module tb_diffusion_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic im0 = 1'b0, im1 = 1'b0, im2 = 1'b0;
  logic or0 = 1'b0, or1 = 1'b0, or2 = 1'b0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [127:0] is0 = '0, os0;
  logic [31:0]  is1 = '0, os1;
  logic [255:0] is2 = '0, os2;

  int n_assert = 0;
  int n_fail   = 0;

  diffusion_engine #(.NB(4)) dut (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_mode(im0),
    .in_state(is0), .out_valid(ov0), .out_ready(or0), .out_state(os0), .busy(bz0)
  );
  diffusion_engine #(.NB(1)) dut_nb1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_mode(im1),
    .in_state(is1), .out_valid(ov1), .out_ready(or1), .out_state(os1), .busy(bz1)
  );
  diffusion_engine #(.NB(8)) dut_nb8 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_mode(im2),
    .in_state(is2), .out_valid(ov2), .out_ready(or2), .out_state(os2), .busy(bz2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic int nb_of(input int idx);
    case (idx)
      0: return 4;
      1: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [255:0] os_of(input int idx);
    case (idx)
      0: return {128'b0, os0};
      1: return {224'b0, os1};
      default: return os2;
    endcase
  endfunction

  function automatic logic ov_of(input int idx);
    case (idx) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction

  function automatic logic ir_of(input int idx);
    case (idx) 0: return ir0; 1: return ir1; default: return ir2; endcase
  endfunction

  function automatic logic bz_of(input int idx);
    case (idx) 0: return bz0; 1: return bz1; default: return bz2; endcase
  endfunction

  task automatic drive(input int idx, input logic v, input logic m, input logic [255:0] s);
    case (idx)
      0: begin iv0 = v; im0 = m; is0 = s[127:0]; end
      1: begin iv1 = v; im1 = m; is1 = s[31:0]; end
      default: begin iv2 = v; im2 = m; is2 = s; end
    endcase
  endtask

  task automatic set_ordy(input int idx, input logic r);
    case (idx) 0: or0 = r; 1: or1 = r; default: or2 = r; endcase
  endtask

  // Reference GF(2^8) product: carry-less multiply, then polynomial long division by 0x11b.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [255:0] ref_block(input int nb, input logic mode, input logic [255:0] blk);
    logic [7:0] m [4][4];
    logic [7:0] row0 [4];
    logic [7:0] acc;
    logic [255:0] res;
    if (mode) begin row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09; end
    else      begin row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01; end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) m[r][k] = row0[(k - r + 4) % 4];
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc ^= ref_mul(m[r][k], blk[32*c + 8*k +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [255:0] rand_block(input int nb);
    logic [255:0] res;
    res = '0;
    for (int c = 0; c < nb; c++) res[32*c +: 32] = $urandom;
    return res;
  endfunction

  // Called 1 time unit after the accept edge; counts edges until out_valid.
  task automatic wait_done(input int idx, input string tag, input logic [255:0] exp);
    int cnt;
    cnt = 0;
    while (!ov_of(idx) && cnt < nb_of(idx) + 4) begin
      check({tag, " busy"}, 256'(bz_of(idx)), 256'(1));
      check({tag, " in_ready low"}, 256'(ir_of(idx)), 256'(0));
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, 256'(cnt), 256'(nb_of(idx)));
    check({tag, " out_valid"}, 256'(ov_of(idx)), 256'(1));
    check({tag, " out_state"}, os_of(idx), exp);
  endtask

  task automatic release_out(input int idx, input string tag);
    set_ordy(idx, 1'b1);
    @(posedge clk); #1;
    set_ordy(idx, 1'b0);
    check({tag, " out_valid drop"}, 256'(ov_of(idx)), 256'(0));
    check({tag, " in_ready back"}, 256'(ir_of(idx)), 256'(1));
  endtask

  task automatic run_block(input int idx, input logic mode, input logic [255:0] blk,
                           input logic [255:0] exp, input string tag);
    check({tag, " in_ready idle"}, 256'(ir_of(idx)), 256'(1));
    drive(idx, 1'b1, mode, blk);
    @(posedge clk); #1;
    drive(idx, 1'b0, ~mode, rand_block(nb_of(idx)));
    wait_done(idx, tag, exp);
    release_out(idx, tag);
  endtask

  logic [255:0] db_blk, db_exp, blk, exp, fwd, other;

  initial begin
    db_blk = {128'b0, {4{32'h455313db}}};
    db_exp = {128'b0, {4{32'hbca14d8e}}};

    #1 reset = 1'b1;
    #12;
    check("reset in_ready", 256'(ir0), 256'(1));
    check("reset out_valid", 256'(ov0), 256'(0));
    check("reset busy", 256'(bz0), 256'(0));
    check("reset out_state", os_of(0), '0);
    @(negedge clk) reset = 1'b0;

    run_block(0, 1'b0, db_blk, db_exp, "fwd db13");

    run_block(0, 1'b1,
              {128'b0, 32'hf8bd7e4d, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e},
              {128'b0, 32'h4c31262d, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db}, "rev vectors");

    blk = {128'b0, 32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6};
    run_block(0, 1'b0, blk, blk, "fixed fwd");
    run_block(0, 1'b1, blk, blk, "fixed rev");

    for (int i = 0; i < 6; i++) begin
      blk = rand_block(4);
      run_block(0, 1'(i & 1), blk, ref_block(4, 1'(i & 1), blk), "random nb4");
    end

    // Backpressure: hold the result, while a competing offer is ignored.
    blk   = rand_block(4);
    exp   = ref_block(4, 1'b0, blk);
    other = rand_block(4);
    drive(0, 1'b1, 1'b0, blk);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, other);
    wait_done(0, "bp first", exp);
    drive(0, 1'b1, 1'b1, other);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_valid hold", 256'(ov0), 256'(1));
      check("bp out_state hold", os_of(0), exp);
      check("bp in_ready low", 256'(ir0), 256'(0));
    end
    release_out(0, "bp release");
    check("bp no same-edge accept", 256'(bz0), 256'(0));
    @(posedge clk); #1;
    check("bp accept after idle", 256'(bz0), 256'(1));
    drive(0, 1'b0, 1'b0, '0);
    wait_done(0, "bp second", ref_block(4, 1'b1, other));
    release_out(0, "bp second");

    // Reset during the second BUSY cycle.
    drive(0, 1'b1, 1'b0, db_blk);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check("pre-reset busy", 256'(bz0), 256'(1));
    #2 reset = 1'b1;
    #1;
    check("mid reset in_ready", 256'(ir0), 256'(1));
    check("mid reset out_valid", 256'(ov0), 256'(0));
    check("mid reset busy", 256'(bz0), 256'(0));
    check("mid reset out_state", os_of(0), '0);
    @(posedge clk); #1;
    check("held reset out_valid", 256'(ov0), 256'(0));
    check("held reset out_state", os_of(0), '0);
    @(negedge clk) reset = 1'b0;
    run_block(0, 1'b0, db_blk, db_exp, "after reset");

    for (int idx = 1; idx <= 2; idx++) begin
      for (int t = 0; t < 3; t++) begin
        blk = rand_block(nb_of(idx));
        fwd = ref_block(nb_of(idx), 1'b0, blk);
        run_block(idx, 1'b0, blk, fwd, idx == 1 ? "nb1 fwd" : "nb8 fwd");
        run_block(idx, 1'b1, fwd, blk, idx == 1 ? "nb1 round trip" : "nb8 round trip");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
